// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN cell family.
package cnn_pkg;

   typedef enum logic [1:0] {IDLE, MAC, SAT, DONE} cnn_state_e;

   localparam int CNN_DW_DEF   = 9;
   localparam int CNN_FRAC_DEF = 4;

   // Wide enough for the shifted bias plus 2*TAPS full-width products.
   function automatic int cnn_acc_width(input int dw, input int taps);
      return 2 * dw + $clog2(2 * taps + 1);
   endfunction

endpackage

// File: rtl/cnn_sat.sv
// Output nonlinearity: floor-shift accumulator by FRAC, clamp state to DW bits and output to +/-1.0.
// Purely combinational; no handshake.
module cnn_sat
   import cnn_pkg::*;
#(
   parameter int DW   = CNN_DW_DEF,
   parameter int FRAC = CNN_FRAC_DEF,
   parameter int AW   = cnn_acc_width(CNN_DW_DEF, 9)
) (
   input  logic signed [AW-1:0] acc_i,
   output logic signed [DW-1:0] x_o,
   output logic signed [DW-1:0] y_o
);

   localparam logic signed [AW-1:0] X_MAX = AW'((2 ** (DW - 1)) - 1);
   localparam logic signed [AW-1:0] X_MIN = AW'(-(2 ** (DW - 1)));
   localparam logic signed [AW-1:0] Y_MAX = AW'(2 ** FRAC);
   localparam logic signed [AW-1:0] Y_MIN = AW'(-(2 ** FRAC));

   logic signed [AW-1:0] x_full;

   always_comb begin
      x_full = acc_i >>> FRAC;
      if (x_full > X_MAX)      x_o = X_MAX[DW-1:0];
      else if (x_full < X_MIN) x_o = X_MIN[DW-1:0];
      else                     x_o = x_full[DW-1:0];
      if (x_full > Y_MAX)      y_o = Y_MAX[DW-1:0];
      else if (x_full < Y_MIN) y_o = Y_MIN[DW-1:0];
      else                     y_o = x_full[DW-1:0];
   end

endmodule

// File: rtl/cnn_cell_seq.sv
// Sequential CNN cell, one template tap per cycle; early stop via CNN_CELL_CONVERGE_EN.
// Latency N*(TAPS+1)+1 cycles from start to done; start is ignored while busy.
module cnn_cell_seq
   import cnn_pkg::*;
#(
   parameter int DW   = CNN_DW_DEF,
   parameter int FRAC = CNN_FRAC_DEF,
   parameter int TAPS = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [TAPS*DW-1:0] a_flat,
   input  logic [TAPS*DW-1:0] b_flat,
   input  logic [TAPS*DW-1:0] u_flat,
   input  logic [TAPS*DW-1:0] y_flat,
   input  logic [DW-1:0]      i_bias,
   input  logic [7:0]         iters,
   output logic               busy,
   output logic               done,
   output logic               converged,
   output logic [DW-1:0]      x_out,
   output logic [DW-1:0]      y_out
);

   localparam int AW = cnn_acc_width(DW, TAPS);
   localparam int C  = TAPS / 2;
   localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

   cnn_state_e           state_q;
   logic [TAPS*DW-1:0]   a_q, b_q, u_q, yt_q;
   logic [DW-1:0]        bias_q;
   logic [7:0]           iter_q;
   logic [TW-1:0]        tap_q;
   logic signed [AW-1:0] acc_q;
   logic                 busy_q, done_q, conv_q;
   logic [DW-1:0]        x_q, yo_q;

   logic signed [DW-1:0]   a_t [TAPS];
   logic signed [DW-1:0]   b_t [TAPS];
   logic signed [DW-1:0]   u_t [TAPS];
   logic signed [DW-1:0]   y_t [TAPS];
   logic signed [2*DW-1:0] p_ay, p_bu;
   logic signed [AW-1:0]   mac_term, bias_in, bias_lat;
   logic signed [DW-1:0]   sat_x, sat_y;
   logic                   conv_hit;

   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      assign a_t[k] = a_q[k*DW +: DW];
      assign b_t[k] = b_q[k*DW +: DW];
      assign u_t[k] = u_q[k*DW +: DW];
      assign y_t[k] = yt_q[k*DW +: DW];
   end

   assign p_ay     = a_t[tap_q] * y_t[tap_q];
   assign p_bu     = b_t[tap_q] * u_t[tap_q];
   assign mac_term = {{(AW-2*DW){p_ay[2*DW-1]}}, p_ay} + {{(AW-2*DW){p_bu[2*DW-1]}}, p_bu};
   assign bias_in  = {{(AW-DW){i_bias[DW-1]}}, i_bias} <<< FRAC;
   assign bias_lat = {{(AW-DW){bias_q[DW-1]}}, bias_q} <<< FRAC;

   cnn_sat #(.DW(DW), .FRAC(FRAC), .AW(AW)) u_sat (
      .acc_i (acc_q),
      .x_o   (sat_x),
      .y_o   (sat_y)
   );

`ifdef CNN_CELL_CONVERGE_EN
   // Set after the first SAT of a run so the comparison sees a real previous output.
   logic prev_vld_q;
   always_ff @(posedge clk) begin
      if (rst)                           prev_vld_q <= 1'b0;
      else if (state_q == IDLE && start) prev_vld_q <= 1'b0;
      else if (state_q == SAT)           prev_vld_q <= 1'b1;
   end
   assign conv_hit = prev_vld_q && (sat_y == yo_q);
`else
   assign conv_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         conv_q  <= 1'b0;
         x_q     <= '0;
         yo_q    <= '0;
         acc_q   <= '0;
         iter_q  <= '0;
         tap_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               a_q     <= a_flat;
               b_q     <= b_flat;
               u_q     <= u_flat;
               yt_q    <= y_flat;
               bias_q  <= i_bias;
               iter_q  <= (iters == 8'd0) ? 8'd1 : iters;
               acc_q   <= bias_in;
               tap_q   <= '0;
               conv_q  <= 1'b0;
               busy_q  <= 1'b1;
               state_q <= MAC;
            end
            MAC: begin
               acc_q <= acc_q + mac_term;
               if (tap_q == TW'(TAPS - 1)) begin
                  tap_q   <= '0;
                  state_q <= SAT;
               end else begin
                  tap_q <= tap_q + 1'b1;
               end
            end
            SAT: begin
               x_q               <= sat_x;
               yo_q              <= sat_y;
               yt_q[C*DW +: DW]  <= sat_y;
               if (iter_q == 8'd1 || conv_hit) begin
                  done_q  <= 1'b1;
                  conv_q  <= conv_hit;
                  state_q <= DONE;
               end else begin
                  iter_q  <= iter_q - 8'd1;
                  acc_q   <= bias_lat;
                  state_q <= MAC;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign converged = conv_q;
   assign x_out     = x_q;
   assign y_out     = yo_q;

endmodule

// File: tb/tb_cnn_cell_seq.sv
// Bench for cnn_cell_seq: behavioural cell model feeds a scoreboard of final results and per-iteration outputs.
module tb_cnn_cell_seq;

   localparam int DW     = 9;
   localparam int FRAC   = 4;
   localparam int TAPS   = 9;
   localparam int C      = TAPS / 2;
   localparam int PER    = TAPS + 1;
   localparam int BUDGET = 600;

   typedef logic [TAPS*DW-1:0] vec_t;
   typedef struct {
      int x;
      int y;
      int lat;
      bit cv;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   vec_t          a_flat, b_flat, u_flat, y_flat;
   logic [DW-1:0] i_bias;
   logic [7:0]    iters;
   logic          busy, done, converged;
   logic [DW-1:0] x_out, y_out;

   int   tests = 0;
   int   fails = 0;
   bit   conv_en;
   exp_t expq[$];
   int   yq[$];

   always #5 clk = ~clk;

   cnn_cell_seq #(.DW(DW), .FRAC(FRAC), .TAPS(TAPS)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a_flat    (a_flat),
      .b_flat    (b_flat),
      .u_flat    (u_flat),
      .y_flat    (y_flat),
      .i_bias    (i_bias),
      .iters     (iters),
      .busy      (busy),
      .done      (done),
      .converged (converged),
      .x_out     (x_out),
      .y_out     (y_out)
   );

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic int tap(input vec_t v, input int k);
      logic signed [DW-1:0] t;
      t = v[k*DW +: DW];
      return int'(t);
   endfunction

   function automatic vec_t one_tap(input int k, input int val);
      vec_t v;
      v = '0;
      v[k*DW +: DW] = val[DW-1:0];
      return v;
   endfunction

   function automatic vec_t rand_vec(input int mag);
      vec_t v;
      int   r;
      v = '0;
      for (int k = 0; k < TAPS; k++) begin
         r = int'($urandom_range(0, 2 * mag)) - mag;
         v[k*DW +: DW] = r[DW-1:0];
      end
      return v;
   endfunction

   // Reference cell: pushes each iteration's output and the final result.
   task automatic model(input vec_t a, input vec_t b, input vec_t u, input vec_t y,
                        input logic [DW-1:0] bias, input logic [7:0] it);
      int n, acc, x, yv, prev, yc, ran;
      bit cv;
      exp_t e;
      logic signed [DW-1:0] sb;
      n = (it == 8'd0) ? 1 : int'(it);
      sb = bias;
      yc = tap(y, C);
      cv = 1'b0; prev = 0; ran = 0; x = 0; yv = 0;
      for (int i = 0; i < n; i++) begin
         acc = int'(sb) * (1 << FRAC);
         for (int k = 0; k < TAPS; k++)
            acc += tap(a, k) * ((k == C) ? yc : tap(y, k)) + tap(b, k) * tap(u, k);
         x  = acc >>> FRAC;
         yv = clamp(x, -(1 << FRAC), 1 << FRAC);
         yq.push_back(yv);
         ran = i + 1;
         if (conv_en && i > 0 && yv == prev) begin
            cv = 1'b1;
            break;
         end
         prev = yv;
         yc   = yv;
      end
      e.x   = clamp(x, -(1 << (DW - 1)), (1 << (DW - 1)) - 1);
      e.y   = yv;
      e.lat = ran * PER + 1;
      e.cv  = cv;
      expq.push_back(e);
   endtask

   task automatic run_job(input string name, input vec_t a, input vec_t b, input vec_t u,
                          input vec_t y, input logic [DW-1:0] bias, input logic [7:0] it,
                          input int restart_at);
      int lat, ey;
      bit seen;
      exp_t e;
      logic [DW-1:0] ex_v, ey_v;
      model(a, b, u, y, bias, it);
      @(negedge clk);
      a_flat = a; b_flat = b; u_flat = u; y_flat = y;
      i_bias = bias; iters = it; start = 1'b1;
      lat = 0; seen = 1'b0;
      while (!seen && lat < BUDGET) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin
            start  = 1'b0;
            a_flat = vec_t'({$urandom, $urandom, $urandom});
            b_flat = vec_t'({$urandom, $urandom, $urandom});
            u_flat = vec_t'({$urandom, $urandom, $urandom});
            y_flat = vec_t'({$urandom, $urandom, $urandom});
            i_bias = DW'($urandom);
            iters  = 8'($urandom);
         end
         if (lat == restart_at)     start = 1'b1;
         if (lat == restart_at + 1) start = 1'b0;
         if (lat > 1 && (lat - 1) % PER == 0 && yq.size() > 0) begin
            ey = yq.pop_front();
            ey_v = ey[DW-1:0];
            tests++;
            if (y_out !== ey_v) begin
               fails++;
               $display("FAIL %s y_seq@%0d: got %0d expected %0d", name, lat, $signed(y_out), ey);
            end
         end
         if (done === 1'b1) seen = 1'b1;
      end
      e = expq.pop_front();
      yq.delete();
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s done_timeout: no done within %0d cycles, expected at %0d", name, BUDGET, e.lat);
      end else if (lat != e.lat) begin
         fails++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
      end
      ex_v = e.x[DW-1:0];
      ey_v = e.y[DW-1:0];
      tests++;
      if (x_out !== ex_v) begin
         fails++;
         $display("FAIL %s x_out: got %0d expected %0d", name, $signed(x_out), e.x);
      end
      tests++;
      if (y_out !== ey_v) begin
         fails++;
         $display("FAIL %s y_out: got %0d expected %0d", name, $signed(y_out), e.y);
      end
      tests++;
      if (converged !== e.cv) begin
         fails++;
         $display("FAIL %s converged: got %b expected %b", name, converged, e.cv);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset busy: got %b expected 0", busy); end
      tests++; if (done !== 1'b0)      begin fails++; $display("FAIL reset done: got %b expected 0", done); end
      tests++; if (converged !== 1'b0) begin fails++; $display("FAIL reset converged: got %b expected 0", converged); end
      tests++; if (x_out !== '0)       begin fails++; $display("FAIL reset x_out: got %0d expected 0", x_out); end
      tests++; if (y_out !== '0)       begin fails++; $display("FAIL reset y_out: got %0d expected 0", y_out); end
      rst = 1'b0;
   endtask

   task automatic test_bias_only();
      run_job("bias_only", '0, '0, '0, '0, DW'(16), 8'd1, 0);
   endtask

   task automatic test_saturation();
      run_job("pos_sat", '0, one_tap(C, 16), one_tap(C, 32), '0, '0, 8'd1, 0);
      run_job("neg_sat", '0, '0, '0, '0, DW'(-40), 8'd1, 0);
      run_job("x_clamp", '0, one_tap(0, 127), one_tap(0, 127), '0, DW'(200), 8'd1, 0);
   endtask

   task automatic test_feedback();
      run_job("feedback", one_tap(C, 32), '0, '0, one_tap(C, 4), '0, 8'd5, 0);
   endtask

   task automatic test_iters_zero();
      run_job("iters_zero", '0, '0, '0, '0, DW'(16), 8'd0, 0);
   endtask

   task automatic test_back_to_back();
      int r;
      for (int j = 0; j < 4; j++) begin
         r = int'($urandom_range(0, 80)) - 40;
         run_job("random", rand_vec(12), rand_vec(12), rand_vec(40), rand_vec(20),
                 r[DW-1:0], 8'($urandom_range(0, 3)), 0);
      end
   endtask

   task automatic test_restart_ignored();
      run_job("restart_ignored", '0, '0, '0, '0, DW'(16), 8'd1, 4);
   endtask

   task automatic test_reset_midrun();
      bit saw_done;
      @(negedge clk);
      a_flat = '0; b_flat = '0; u_flat = '0; y_flat = '0;
      i_bias = DW'(16); iters = 8'd3; start = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL midrun_rst busy: got %b expected 0", busy); end
      tests++; if (done !== 1'b0)      begin fails++; $display("FAIL midrun_rst done: got %b expected 0", done); end
      tests++; if (converged !== 1'b0) begin fails++; $display("FAIL midrun_rst converged: got %b expected 0", converged); end
      tests++; if (x_out !== '0)       begin fails++; $display("FAIL midrun_rst x_out: got %0d expected 0", x_out); end
      tests++; if (y_out !== '0)       begin fails++; $display("FAIL midrun_rst y_out: got %0d expected 0", y_out); end
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      tests++;
      if (saw_done) begin
         fails++;
         $display("FAIL midrun_rst abandoned: got activity after reset expected idle");
      end
      run_job("after_rst", one_tap(C, 32), '0, '0, one_tap(C, 4), DW'(2), 8'd2, 0);
   endtask

   initial begin
`ifdef CNN_CELL_CONVERGE_EN
      conv_en = 1'b1;
`else
      conv_en = 1'b0;
`endif
      rst = 1'b1; start = 1'b0;
      a_flat = '0; b_flat = '0; u_flat = '0; y_flat = '0;
      i_bias = '0; iters = '0;
      test_reset();
      test_bias_only();
      test_saturation();
      test_feedback();
      test_iters_zero();
      test_back_to_back();
      test_restart_ignored();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cnn_cell_seq.md
CNN_CELL_SEQ -- requirements
Module: cnn_cell_seq

Interface
REQ-001 SHALL have parameter DW, default 9: signed operand width, two's complement.
REQ-002 SHALL have parameter FRAC, default 4: fractional bits of every operand (1.0 = 2^FRAC); legal range FRAC <= DW-2.
REQ-003 SHALL have parameter TAPS, default 9: neighbourhood size; centre tap index C = TAPS/2 (integer division).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request; accepted only in IDLE.
REQ-007 a_flat  in  TAPS*DW  feedback template; tap k at bits [k*DW +: DW].
REQ-008 b_flat  in  TAPS*DW  control template; same packing.
REQ-009 u_flat  in  TAPS*DW  neighbour inputs; same packing.
REQ-010 y_flat  in  TAPS*DW  neighbour outputs; centre tap is the initial self output.
REQ-011 i_bias  in  DW  bias I.
REQ-012 iters  in  8  iteration count; 0 treated as 1.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at completion.
REQ-015 converged  out  1  early-stop flag, valid with done.
REQ-016 x_out  out  DW  cell state; y_out  out  DW  cell output.

Function
REQ-017 On start in IDLE, SHALL latch all templates, u, y, i_bias and iters, and go to MAC; start outside IDLE is ignored.
REQ-018 States: IDLE -> MAC (TAPS cycles, one tap per cycle) -> SAT (1 cycle) -> MAC if iterations remain, else DONE (1 cycle, done=1) -> IDLE.
REQ-019 The accumulator is initialised to i_bias<<FRAC at MAC entry; each MAC cycle adds a[k]*y[k] + b[k]*u[k]; width 2*DW+clog2(2*TAPS+1), no overflow possible.
REQ-020 In SAT, x = acc >>> FRAC (arithmetic, floor); x_out = x clamped to the signed DW range; y_out = x clamped to [-(2^FRAC), +(2^FRAC)].
REQ-021 In SAT, the new y_out SHALL replace latched centre tap y[C]; neighbour y and all u stay fixed for the run.
REQ-022 Latency: done is high exactly N*(TAPS+1)+1 cycles after the start cycle, N = effective iteration count.
REQ-023 x_out and y_out update only in SAT and hold between runs.

Reset
REQ-024 rst SHALL force IDLE; busy, done, converged, x_out, y_out, the accumulator and the iteration counter go to 0 on the next edge, including mid-run; the run is abandoned.

Configuration
REQ-025 With CNN_CELL_CONVERGE_EN defined: after the second and each later SAT, if the new y_out equals the previous y_out, go to DONE with converged=1, skipping the remaining iterations.
REQ-026 Without CNN_CELL_CONVERGE_EN: all N iterations run and converged is tied to 0; the port list is identical in both builds.

Structure
REQ-027 Shared package cnn_pkg SHALL hold the state enum (IDLE, MAC, SAT, DONE), the DW/FRAC defaults and the accumulator-width function.
REQ-028 The output nonlinearity SHALL be a sub-module cnn_sat (combinational shift-and-clamp), reused by later array blocks.

Verification (DW=9, FRAC=4, TAPS=9)
REQ-029 All A=B=0, i_bias=16, iters=1 -> x_out=16, y_out=16, done at cycle 11.
REQ-030 B[4]=16, u[4]=32, others 0, i_bias=0 -> x_out=32, y_out=16 (positive saturation); i_bias=-40 alone -> x_out=-40, y_out=-16.
REQ-031 A[4]=32, y[4]=4, others 0, iters=5 -> y_out sequence 8, 16, 16, 16, 16; done at cycle 51 without the macro; with CNN_CELL_CONVERGE_EN -> done at cycle 31, converged=1.
REQ-032 iters=0 -> behaves as iters=1 (done at cycle 11).
REQ-033 start re-asserted while busy -> ignored, result unchanged; rst asserted at MAC cycle 5 -> next cycle busy=0, outputs 0; a fresh start then completes normally.
